// File: rtl/addsub_pipe.sv
// addsub_pipe: two-stage pipelined two's-complement adder/subtractor with accumulator,
// carry/overflow flags and valid/ready on both sides. Define ADDSUB_SAT_EN to saturate on overflow.
module addsub_pipe #(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] I0,
    input  logic [WIDTH-1:0] I1,
    input  logic             SUB,
    input  logic             ACC,
    input  logic             CLR,
    input  logic             IN_VALID,
    output logic             IN_READY,
    output logic [WIDTH-1:0] O,
    output logic             COUT,
    output logic             OVF,
    output logic             OUT_VALID,
    input  logic             OUT_READY
);

    logic             rdy_q;

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_a_q, s1_b_q;
    logic             s1_cin_q, s1_acc_q, s1_clr_q;

    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] o_q, o_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] acc_q;

    logic             s1_advance;
    logic             in_accept;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH:0]   sum;
    logic             c_msb;

    assign s1_advance = s1_valid_q & (~s2_valid_q | OUT_READY);
    assign IN_READY   = rdy_q & (~s1_valid_q | s1_advance);
    assign in_accept  = IN_VALID & IN_READY;
    assign s1_valid_d = in_accept | (s1_valid_q & ~s1_advance);
    assign s2_valid_d = s1_advance | (s2_valid_q & ~OUT_READY);

    always_comb begin
        // NOTE: every output of this block gets a value on every path, so no latch is inferred.
        op_a   = s1_acc_q ? acc_q : s1_a_q;
        sum    = {1'b0, op_a} + {1'b0, s1_b_q} + (WIDTH+1)'(s1_cin_q);
        // Carry into the MSB recovered from the MSB sum bit and its two operand bits.
        c_msb  = sum[WIDTH-1] ^ op_a[WIDTH-1] ^ s1_b_q[WIDTH-1];
        cout_d = sum[WIDTH];
        ovf_d  = c_msb ^ sum[WIDTH];
        o_d    = sum[WIDTH-1:0];
`ifdef ADDSUB_SAT_EN
        // On overflow both effective operands share a sign, which is the sign of the true result.
        if (ovf_d) begin
            o_d = op_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
    end

    // IN_READY is held low during reset and rises on the first clock after release.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            rdy_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every stage samples the pre-edge state of the stage before it.
            rdy_q <= 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_cin_q   <= 1'b0;
            s1_acc_q   <= 1'b0;
            s1_clr_q   <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            if (in_accept) begin
                s1_a_q   <= I0;
                s1_b_q   <= SUB ? ~I1 : I1;
                s1_cin_q <= SUB;
                s1_acc_q <= ACC;
                s1_clr_q <= CLR;
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            s2_valid_q <= 1'b0;
            o_q        <= '0;
            cout_q     <= 1'b0;
            ovf_q      <= 1'b0;
            acc_q      <= ACC_INIT;
        end else begin
            s2_valid_q <= s2_valid_d;
            if (s1_advance) begin
                o_q    <= o_d;
                cout_q <= cout_d;
                ovf_q  <= ovf_d;
                acc_q  <= s1_clr_q ? ACC_INIT : o_d;
            end
        end
    end

    assign O         = o_q;
    assign COUT      = cout_q;
    assign OVF       = ovf_q;
    assign OUT_VALID = s2_valid_q;

endmodule

// File: tb/tb_addsub_pipe.sv
// tb_addsub_pipe: randomized + directed bench for addsub_pipe (WIDTH=8) against an arithmetic model.
module tb_addsub_pipe;

    localparam int         WIDTH    = 8;
    localparam logic [7:0] ACC_INIT = 8'h00;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [7:0] I0, I1;
    logic       SUB, ACC, CLR, IN_VALID, OUT_READY;
    logic       IN_READY, COUT, OVF, OUT_VALID;
    logic [7:0] O;

    addsub_pipe #(.WIDTH(WIDTH), .ACC_INIT(ACC_INIT)) dut (
        .CLK(CLK), .RESET(RESET), .I0(I0), .I1(I1), .SUB(SUB), .ACC(ACC), .CLR(CLR),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY), .O(O), .COUT(COUT), .OVF(OVF),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [7:0] o;
        logic       c;
        logic       v;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] obs_q[$];
    int         obs_cyc[$];
    logic [7:0] acc_m;
    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    logic       hold_valid = 1'b0;
    logic [7:0] hold_o;
    logic       hold_c, hold_v;
    logic [7:0] last_o;
    logic       last_c, last_v;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    // Plain integer arithmetic; transactions complete in order, so the accumulator is modelled at accept.
    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b,
                                   input logic sub, input logic acc, input logic clr);
        exp_t       r;
        logic [7:0] av;
        int         ua, ub, sa, sb, u, s;
        av = acc ? acc_m : a;
        ua = int'(av);
        ub = int'(b);
        sa = int'($signed(av));
        sb = int'($signed(b));
        u  = sub ? ua - ub : ua + ub;
        s  = sub ? sa - sb : sa + sb;
        r.c = sub ? (ua >= ub) : (u > 255);
        r.v = (s > 127) || (s < -128);
        r.o = 8'(u & 255);
`ifdef ADDSUB_SAT_EN
        if (r.v) r.o = (s > 0) ? 8'h7F : 8'h80;
`endif
        acc_m = clr ? ACC_INIT : r.o;
        return r;
    endfunction

    // One clock: drive at negedge, evaluate handshakes, advance to the next negedge.
    task automatic step(input logic v, input logic [7:0] a, input logic [7:0] b, input logic sub,
                        input logic acc, input logic clr, input logic rdy, output logic accepted);
        exp_t e;
        IN_VALID  = v;
        I0        = a;
        I1        = b;
        SUB       = sub;
        ACC       = acc;
        CLR       = clr;
        OUT_READY = rdy;
        #1;
        if (hold_valid) begin
            check("stall_valid", OUT_VALID, 1);
            check("stall_o", O, hold_o);
            check("stall_flags", {COUT, OVF}, {hold_c, hold_v});
            hold_valid = 1'b0;
        end
        accepted = v & IN_READY;
        if (OUT_VALID && rdy) begin
            if (exp_q.size() == 0) begin
                check("spurious_out", OUT_VALID, 0);
            end else begin
                e = exp_q.pop_front();
                check("o", O, e.o);
                check("cout", COUT, e.c);
                check("ovf", OVF, e.v);
                obs_q.push_back(O);
                obs_cyc.push_back(cyc);
                last_o = O;
                last_c = COUT;
                last_v = OVF;
            end
        end
        if (OUT_VALID && !rdy) begin
            hold_valid = 1'b1;
            hold_o     = O;
            hold_c     = COUT;
            hold_v     = OVF;
        end
        if (accepted) exp_q.push_back(model(a, b, sub, acc, clr));
        cyc++;
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic drain();
        logic dummy;
        for (int i = 0; i < 20; i++) begin
            if (exp_q.size() == 0 && !OUT_VALID) break;
            step(0, 8'h00, 8'h00, 0, 0, 0, 1, dummy);
        end
        check("drain_empty", exp_q.size(), 0);
        check("drain_idle", OUT_VALID, 0);
    endtask

    task automatic one(input logic [7:0] a, input logic [7:0] b, input logic sub);
        logic acc_ok;
        step(1, a, b, sub, 0, 0, 1, acc_ok);
        check("one_accept", acc_ok, 1);
        drain();
    endtask

    initial begin
        logic ok, ok2;
        int   n_acc;

        RESET = 1'b1; IN_VALID = 0; I0 = 0; I1 = 0; SUB = 0; ACC = 0; CLR = 0; OUT_READY = 1;
        acc_m = ACC_INIT;
        @(negedge CLK);
        check("rst_out_valid", OUT_VALID, 0);
        check("rst_o", O, 0);
        check("rst_in_ready", IN_READY, 0);
        RESET = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        check("post_rst_in_ready", IN_READY, 1);

        // Latency: accepted at one edge, visible after the second.
        step(1, 8'h05, 8'h03, 1, 0, 0, 1, ok);
        check("lat_accept", ok, 1);
        #1 check("lat_s1_only", OUT_VALID, 0);
        step(0, 8'h00, 8'h00, 0, 0, 0, 1, ok);
        #1;
        check("lat_valid", OUT_VALID, 1);
        check("lat_o", O, 8'h02);
        check("lat_cout", COUT, 1);
        check("lat_ovf", OVF, 0);
        drain();

        one(8'h03, 8'h05, 1);
        check("borrow_o", last_o, 8'hFE);
        check("borrow_flags", {last_c, last_v}, 2'b00);

        one(8'h7F, 8'h01, 0);
`ifdef ADDSUB_SAT_EN
        check("ovf_o", last_o, 8'h7F);
`else
        check("ovf_o", last_o, 8'h80);
`endif
        check("ovf_flags", {last_c, last_v}, 2'b01);

        one(8'h80, 8'h01, 1);
        check("neg_ovf_flag", last_v, 1);

        // Accumulate chain, back to back.
        obs_q.delete();
        obs_cyc.delete();
        step(1, 8'h00, 8'h00, 0, 0, 1, 1, ok);
        n_acc = int'(ok);
        for (int i = 0; i < 3; i++) begin
            step(1, 8'h00, 8'h10, 0, 1, 0, 1, ok);
            n_acc += int'(ok);
        end
        check("chain_accepts", n_acc, 4);
        drain();
        check("chain_count", obs_q.size(), 4);
        for (int i = 0; i < obs_q.size(); i++) begin
            check("chain_o", obs_q[i], 32'(i * 16));
            check("chain_consecutive", obs_cyc[i] - obs_cyc[0], i);
        end

        // Stall with OUT_READY low.
        step(1, 8'h11, 8'h22, 0, 0, 0, 0, ok);
        step(1, 8'h40, 8'h01, 1, 0, 0, 0, ok2);
        check("stall_two_accepted", {ok, ok2}, 2'b11);
        #1 check("stall_in_ready", IN_READY, 0);
        for (int i = 0; i < 3; i++) begin
            step(1, 8'h09, 8'h0A, 0, 0, 0, 0, ok);
            check("stall_no_accept", ok, 0);
        end
        ok = 0;
        for (int i = 0; i < 10 && !ok; i++) step(1, 8'h09, 8'h0A, 0, 0, 0, 1, ok);
        check("stall_third_accepted", ok, 1);
        drain();

        // Asynchronous reset with both stages full and a non-init accumulator.
        step(1, 8'h11, 8'h22, 0, 0, 0, 0, ok);
        step(1, 8'h01, 8'h02, 0, 0, 0, 0, ok);
        IN_VALID = 0;
        #2 RESET = 1'b1;
        #1;
        check("arst_out_valid", OUT_VALID, 0);
        check("arst_o", O, 0);
        check("arst_flags", {COUT, OVF}, 2'b00);
        check("arst_in_ready", IN_READY, 0);
        check("arst_acc", dut.acc_q, ACC_INIT);
        exp_q.delete();
        acc_m      = ACC_INIT;
        hold_valid = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        check("arst_release_ready", IN_READY, 1);
        step(1, 8'hAA, 8'h05, 0, 1, 0, 1, ok);
        check("arst_new_accept", ok, 1);
        drain();
        check("arst_new_o", last_o, 8'h05);

        // Randomized traffic with random backpressure.
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 9) < 7, 8'($urandom), 8'($urandom), 1'($urandom),
                 1'($urandom), $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 7, ok);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule

// File: doc/addsub_pipe.md
Name: addsub_pipe

Overview:
- Parametrised, pipelined two's-complement adder/subtractor for the icestick mantle arithmetic library.
- Successor to the combinational invert-plus-ripple subtractor. Adds these features:
  - runtime ADD/SUB select with a correct carry-in;
  - an accumulate mode;
  - carry and overflow flags;
  - valid/ready handshaking on both sides.
- Intended between register-file/IO logic and downstream consumers; maps onto SB_LUT4 + SB_CARRY chains.

Parameters:
- WIDTH, 8, operand/result width in bits (>=2).
- ACC_INIT, 0, value loaded into the accumulator on reset and on CLR.

Ports:
- CLK  input  1  rising-edge clock.
- RESET  input  1  asynchronous, active-high reset.
- I0  input  WIDTH  operand A.
- I1  input  WIDTH  operand B.
- SUB  input  1  1 = A-B, 0 = A+B.
- ACC  input  1  1 = replace A with current accumulator value.
- CLR  input  1  load accumulator with ACC_INIT when the transaction is accepted.
- IN_VALID  input  1  input transaction valid.
- IN_READY  output  1  block can accept input this cycle.
- O  output  WIDTH  result.
- COUT  output  1  carry out of MSB (for SUB: 1 = no borrow).
- OVF  output  1  signed overflow.
- OUT_VALID  output  1  result valid.
- OUT_READY  input  1  consumer accepts result.

Behaviour:
- Two register stages: S1 (operand capture), S2 (result). Latency is 2 cycles from input accept to OUT_VALID with no stall.
- Handshake rules:
  - Input is accepted when IN_VALID & IN_READY.
  - Output is transferred when OUT_VALID & OUT_READY.
  - OUT_VALID and O/COUT/OVF stay stable until transferred.
- IN_READY = !s1_valid | s1_advance.
- s1_advance = s1_valid & (!s2_valid | OUT_READY). Full throughput is 1/cycle when OUT_READY stays high.
- S1 captures the following when accepted:
  - a = I0;
  - b = SUB ? ~I1 : I1;
  - cin = SUB;
  - ACC and CLR flags.
- S2 computes {COUT,O} = A + b + cin, WIDTH+1 bits, where A = acc_ACC ? acc_reg : a.
- OVF = carry into MSB XOR carry out of MSB.
- acc_reg updates only when S2 loads:
  - CLR=1: acc_reg <= ACC_INIT. O still shows the computed sum, which uses the pre-clear acc_reg if ACC=1.
  - CLR=0: acc_reg <= O_next.
- Back-to-back ACC transactions must chain correctly: each uses the immediately preceding result. acc_reg is updated at S2 load, so there is no hazard.
- Wrap-around: results are modulo 2^WIDTH (no saturation unless the option below is compiled in).
- RESET (any time, including mid-transaction) clears the pipeline:
  - s1_valid = s2_valid = 0, OUT_VALID = 0;
  - O = 0, COUT = 0, OVF = 0;
  - acc_reg = ACC_INIT;
  - IN_READY = 1 one cycle after RESET deasserts, and 0 while RESET is high.
  - In-flight transactions are discarded.
- Stall: OUT_READY=0 with both stages full gives IN_READY=0. No data is lost or duplicated.

Optional Feature:
- Macro ADDSUB_SAT_EN.
- When defined, S2 saturates on OVF: O = 0x7F..F if the true result is positive, 0x80..0 if negative. OVF is still reported and acc_reg stores the saturated value.
- When undefined, O wraps modulo 2^WIDTH and there is no saturation logic.

Test Plan:
- WIDTH=8. Accept I0=0x05, I1=0x03, SUB=1 -> 2 cycles later O=0x02, COUT=1, OVF=0, OUT_VALID=1.
- I0=0x03, I1=0x05, SUB=1 -> O=0xFE, COUT=0 (borrow), OVF=0.
- I0=0x7F, I1=0x01, SUB=0 -> O=0x80, OVF=1, COUT=0. With ADDSUB_SAT_EN: O=0x7F, OVF=1.
- Accumulate chain:
  - CLR=1 with I0=0,I1=0 first, then ACC=1, SUB=0, I1=0x10 on 3 consecutive cycles;
  - expected O sequence 0x00, 0x10, 0x20, 0x30 on consecutive cycles with OUT_READY=1.
- Hold OUT_READY=0 while feeding 3 inputs:
  - IN_READY drops after 2 accepted;
  - OUT_VALID and O stay stable;
  - release OUT_READY -> all results emerge in order, none lost or duplicated.
- Assert RESET with both stages full:
  - OUT_VALID=0, O=0, acc_reg=ACC_INIT immediately (asynchronous);
  - after release, IN_READY=1 and a new transaction completes with the correct result.
